nrisc_idata_responder: RTL
==========================

// Module: nrisc_idata_responder
// PURPOSE
//  Instruction-memory responder for the NRISC fetch path. Answers program-counter fetch
//  requests (address in, 16-bit instruction word out) with fixed 1-cycle latency.
//  Includes a byte-stream loader port (UART/boot side) that fills the array at power-up.
//  Holds the core stalled while a load is in progress.
// PARAMETERS
//  ADDR_TAM   `ADDR_TAM  fetch address width (bits)
//  MEM_DEPTH  1024       number of 16-bit words implemented (<= 2**ADDR_TAM)
// PORTS
//  clk              in   1         single system clock, all logic on posedge
//  rst              in   1         asynchronous, active-low reset
//  IDATA_CORE_addr  in   ADDR_TAM  fetch address from PC controller
//  IDATA_en         in   1         fetch enable (ungated stall term; 1 = fetch this cycle)
//  IDATA_CORE_out   out  16        instruction word to PC controller
//  IDATA_addr_err   out  1         sticky: fetch addressed >= MEM_DEPTH
//  LOAD_start       in   1         1-cycle pulse: begin program load at word 0
//  LOAD_valid       in   1         LOAD_data valid
//  LOAD_data        in   8         program byte, high byte of each word first
//  LOAD_last        in   1         qualifies final byte of image
//  LOAD_ready       out  1         block accepts byte when LOAD_valid & LOAD_ready
//  LOAD_ovf         out  1         sticky: image exceeded MEM_DEPTH words
//  CORE_hold        out  1         1 = core must stall (load in progress)
// BEHAVIOUR
//  Reset (rst=0, async): state RUN; IDATA_CORE_out=16'h0000; LOAD_ready=0; CORE_hold=0;
//   IDATA_addr_err=0; LOAD_ovf=0; write pointer=0; memory array NOT cleared.
//  FSM: RUN -> LOAD_HI -> LOAD_LO -> WRITE -> (LOAD_HI | DONE) -> RUN.
//  RUN: posedge with IDATA_en=1 registers mem[IDATA_CORE_addr] into IDATA_CORE_out;
//   data visible the cycle after the address (latency 1). IDATA_en=0: output holds.
//   Address >= MEM_DEPTH: output 16'h0000 (NOP), IDATA_addr_err set until reset.
//   LOAD_start=1: next state LOAD_HI, write pointer=0, LOAD_ovf cleared, CORE_hold=1.
//  LOAD_HI: LOAD_ready=1; accepted byte -> word[15:8]. If LOAD_last on this byte,
//   word[7:0]=8'h00 and go to WRITE with end flag set.
//  LOAD_LO: LOAD_ready=1; accepted byte -> word[7:0]; go to WRITE (end flag = LOAD_last).
//  WRITE: LOAD_ready=0, one cycle. Pointer < MEM_DEPTH: mem[ptr]=word. Else drop the write
//   and set LOAD_ovf. Pointer increments, saturating at MEM_DEPTH (no wrap to 0).
//   Next state: DONE if end flag set, else LOAD_HI.
//  DONE: one cycle, LOAD_ready=0, IDATA_CORE_out forced 16'h0000; then RUN, CORE_hold=0.
//  In all non-RUN states: IDATA_CORE_out=16'h0000, CORE_hold=1, fetches ignored.
//  LOAD_start outside RUN: ignored. LOAD_valid with LOAD_ready=0: byte not consumed
//   (source holds it).
//  Same-cycle fetch + LOAD_start in RUN: fetch completes, load starts next cycle.
//  Reset mid-load: returns to RUN immediately, CORE_hold=0. Words already written are
//   kept; a partial word is discarded.
// CONFIGURATION
//  IDATA_PARITY_EN defined: array is 17 bits wide; WRITE stores even parity of word.
//   On a RUN fetch with parity mismatch: IDATA_CORE_out=16'h0000 and output
//   IDATA_par_err (1 bit, sticky, reset 0) is set.
//  Not defined: 16-bit array; no parity logic; IDATA_par_err port absent.
// TESTING
//  1. Reset, load bytes 12 34 56 78 (last on 78) -> mem[0]=16'h1234, mem[1]=16'h5678;
//     CORE_hold 1 from cycle after start until the cycle after DONE.
//  2. RUN, addr 0 then 1 with IDATA_en=1 -> out 1234 then 5678, one cycle after each addr;
//     IDATA_en=0 -> out holds 5678.
//  3. Fetch addr MEM_DEPTH -> out 0000, IDATA_addr_err=1, stays 1 until rst=0.
//  4. MEM_DEPTH=4, load 5 words -> mem[0..3] written, 5th dropped, LOAD_ovf=1,
//     FSM returns to RUN.
//  5. Odd byte count (AB last on hi byte) -> stored word 16'hAB00; rst=0 mid-load after
//     1 byte -> RUN, CORE_hold=0, mem[ptr] unchanged.
//  6. IDATA_PARITY_EN: corrupt parity bit of mem[2] via backdoor, fetch 2 -> out 0000,
//     IDATA_par_err=1.

Source files
------------

// File: rtl/nrisc_idata_responder.sv
// NRISC instruction-memory responder: 1-cycle fetch port plus a byte-stream boot loader.
// Optional parity protection of the array is enabled by defining IDATA_PARITY_EN.
`ifndef ADDR_TAM
`define ADDR_TAM 10
`endif

// state     | meaning
// S_RUN     | serve core fetches, accept LOAD_start
// S_LOAD_HI | wait for high byte of the next word
// S_LOAD_LO | wait for low byte of the current word
// S_WRITE   | commit assembled word at the write pointer
// S_DONE    | one settle cycle before releasing the core
module nrisc_idata_responder #(
  parameter int ADDR_TAM  = `ADDR_TAM,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_TAM-1:0] IDATA_CORE_addr,
  input  logic                IDATA_en,
  output logic [15:0]         IDATA_CORE_out,
  output logic                IDATA_addr_err,
`ifdef IDATA_PARITY_EN
  output logic                IDATA_par_err,
`endif
  input  logic                LOAD_start,
  input  logic                LOAD_valid,
  input  logic [7:0]          LOAD_data,
  input  logic                LOAD_last,
  output logic                LOAD_ready,
  output logic                LOAD_ovf,
  output logic                CORE_hold
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W = $clog2(MEM_DEPTH + 1);
`ifdef IDATA_PARITY_EN
  localparam int MEM_W = 17;
`else
  localparam int MEM_W = 16;
`endif

  typedef enum logic [2:0] {
    S_RUN,
    S_LOAD_HI,
    S_LOAD_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [MEM_W-1:0]   r_mem [MEM_DEPTH];
  logic [15:0]        r_word;
  logic               r_end;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_ovf;
  logic [15:0]        r_out;
  logic               r_addr_err;
  logic               w_accept;
  logic               w_addr_ok;
  logic               w_ptr_ok;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [MEM_W-1:0]   w_rd_word;
  logic [MEM_W-1:0]   w_wr_word;
  logic               w_par_bad;

  assign LOAD_ready = (r_state == S_LOAD_HI) || (r_state == S_LOAD_LO);
  assign w_accept   = LOAD_valid && LOAD_ready;
  assign w_addr_ok  = 32'(IDATA_CORE_addr) < MEM_DEPTH;
  assign w_ptr_ok   = 32'(r_ptr) < MEM_DEPTH;
  assign w_mem_we   = (r_state == S_WRITE) && w_ptr_ok;
  assign w_rd_idx   = IDATA_CORE_addr[IDX_W-1:0];
  assign w_wr_idx   = r_ptr[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_rd_idx];

`ifdef IDATA_PARITY_EN
  // Stored bit 16 makes the 17-bit word even parity; any odd XOR marks corruption.
  logic r_par_err;
  assign w_wr_word     = {^r_word, r_word};
  assign w_par_bad     = ^w_rd_word;
  assign IDATA_par_err = r_par_err;
`else
  assign w_wr_word = r_word;
  assign w_par_bad = 1'b0;
`endif

  assign IDATA_CORE_out = (r_state == S_RUN) ? r_out : 16'h0000;
  assign IDATA_addr_err = r_addr_err;
  assign LOAD_ovf       = r_ovf;
  assign CORE_hold      = (r_state != S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:     if (LOAD_start) w_next = S_LOAD_HI;
      S_LOAD_HI: if (w_accept)   w_next = LOAD_last ? S_WRITE : S_LOAD_LO;
      S_LOAD_LO: if (w_accept)   w_next = S_WRITE;
      S_WRITE:   w_next = r_end ? S_DONE : S_LOAD_HI;
      S_DONE:    w_next = S_RUN;
      default:   w_next = S_RUN;
    endcase
  end

  // Array is deliberately not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_wr_idx] <= w_wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word     <= '0;
      r_end      <= 1'b0;
      r_ptr      <= '0;
      r_ovf      <= 1'b0;
      r_out      <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (r_state != S_RUN) r_out <= '0;
      case (r_state)
        S_RUN: begin
          if (IDATA_en) begin
            if (!w_addr_ok) begin
              r_out      <= '0;
              r_addr_err <= 1'b1;
            end else if (w_par_bad) begin
              r_out <= '0;
            end else begin
              r_out <= w_rd_word[15:0];
            end
          end
          if (LOAD_start) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
          end
        end
        S_LOAD_HI: begin
          if (w_accept) begin
            r_word <= {LOAD_data, 8'h00};
            r_end  <= LOAD_last;
          end
        end
        S_LOAD_LO: begin
          if (w_accept) begin
            r_word[7:0] <= LOAD_data;
            r_end       <= LOAD_last;
          end
        end
        S_WRITE: begin
          // Pointer saturates at MEM_DEPTH so every later word is flagged as overflow.
          if (w_ptr_ok) r_ptr <= r_ptr + PTR_W'(1);
          else          r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IDATA_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                    r_par_err <= 1'b0;
    else if (r_state == S_RUN && IDATA_en && w_addr_ok && w_par_bad) r_par_err <= 1'b1;
  end
`endif

endmodule
